// File: rtl/clkdiv_meter.sv
// Clock-divider meter: measures rise-to-rise period and high time of a slow signal in the clk
// domain, with lock and loss-of-signal detection. Define CLKMETER_SYNC_EN for a 2-flop input sync.
module clkdiv_meter #(
  parameter int unsigned W          = 16,
  parameter int unsigned TIMEOUT    = 65535,
  parameter int unsigned LOCK_COUNT = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         period_valid,
  output logic         locked,
  output logic         timeout
);

  localparam logic [W-1:0] CntMax     = '1;
  localparam logic [W-1:0] TimeoutVal = W'(TIMEOUT);
  localparam logic [3:0]   LockVal    = 4'(LOCK_COUNT);

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e       state_q;
  logic         s0_q, s1_q;
  logic [W-1:0] cnt_q, hi_cnt_q;
  logic [W-1:0] period_q, high_time_q;
  logic [3:0]   match_q;
  logic         have_prev_q;
  logic         period_valid_q, locked_q, timeout_q;

  logic         sig;
  logic         rise;
  logic [W-1:0] cnt_inc, hi_inc;
  logic [3:0]   match_inc;

`ifdef CLKMETER_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
    end
  end

  assign sig = sync2_q;
`else
  assign sig = sig_in;
`endif

  always_comb begin
    rise      = s0_q & ~s1_q;
    cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    hi_inc    = (hi_cnt_q == CntMax) ? hi_cnt_q : hi_cnt_q + 1'b1;
    match_inc = (match_q == LockVal) ? match_q : match_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      s0_q           <= 1'b0;
      s1_q           <= 1'b0;
      cnt_q          <= '0;
      hi_cnt_q       <= '0;
      period_q       <= '0;
      high_time_q    <= '0;
      match_q        <= '0;
      have_prev_q    <= 1'b0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      s0_q           <= sig;
      s1_q           <= s0_q;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            state_q     <= StMeasure;
            cnt_q       <= W'(1);
            hi_cnt_q    <= W'(1);
            have_prev_q <= 1'b0;
          end
        end
        StMeasure: begin
          if (rise) begin
            period_q       <= cnt_q;
            high_time_q    <= hi_cnt_q;
            period_valid_q <= 1'b1;
            cnt_q          <= W'(1);
            hi_cnt_q       <= W'(1);
            have_prev_q    <= 1'b1;
            // The first period after entering MEASURE never counts toward lock.
            if (have_prev_q && (cnt_q == period_q)) begin
              match_q  <= match_inc;
              locked_q <= (match_inc == LockVal);
            end else begin
              match_q  <= '0;
              locked_q <= 1'b0;
            end
          end else if (cnt_q == TimeoutVal) begin
            state_q   <= StIdle;
            timeout_q <= 1'b1;
            locked_q  <= 1'b0;
            match_q   <= '0;
            cnt_q     <= '0;
            hi_cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_inc;
            if (s0_q) begin
              hi_cnt_q <= hi_inc;
            end
          end
        end
      endcase
    end
  end

  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_clkdiv_meter.sv
// Directed bench for clkdiv_meter: expected period/high_time/locked are derived from the driven
// waveform, queued at each input rise and checked when period_valid pulses.
module tb_clkdiv_meter;

  localparam int W  = 16;
  localparam int TO = 20;
  localparam int LC = 3;
`ifdef CLKMETER_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  typedef struct packed {
    logic [W-1:0] p;
    logic [W-1:0] h;
    logic         l;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         period_valid;
  logic         locked;
  logic         timeout;

  clkdiv_meter #(
    .W          (W),
    .TIMEOUT    (TO),
    .LOCK_COUNT (LC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sig_in       (sig_in),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  int n_valid = 0, n_to = 0;
  int last_valid_cyc = -1, first_valid_cyc = -1, to_cyc = -1, first_push_edge = -1;

  // Waveform model state
  logic last_v = 1'b0;
  logic pend_valid = 1'b0;
  int   cur_n = 0, cur_h = 0;
  logic have_prev = 1'b0;
  int   last_p = 0;
  int   m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    pend_valid = 1'b0;
    have_prev  = 1'b0;
    m          = 0;
  endtask

  task automatic step(input logic v);
    exp_t e;
    logic pushed;
    pushed = 1'b0;
    if (v && !last_v) begin
      if (pend_valid) begin
        if (have_prev && cur_n == last_p) m = (m == LC) ? m : m + 1;
        else m = 0;
        have_prev = 1'b1;
        last_p    = cur_n;
        e.p = W'(cur_n);
        e.h = W'(cur_h);
        e.l = (m == LC);
        q.push_back(e);
        pushed = 1'b1;
      end
      pend_valid = 1'b1;
      cur_n      = 0;
      cur_h      = 0;
    end
    cur_n++;
    if (v) cur_h++;
    last_v = v;
    sig_in = v;
    @(posedge clk);
    #1;
    if (pushed && first_push_edge < 0) first_push_edge = cyc;
  endtask

  task automatic pattern(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < hi; j++) step(1'b1);
      for (int j = 0; j < lo; j++) step(1'b0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (period_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      checks++;
      assert (q.size() > 0)
      else begin
        errors++;
        $error("FAIL unexpected_valid: observed pulse with period %0d expected none", period);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("period", period, e.p);
        chk("high_time", high_time, e.h);
        chk("locked_at_valid", locked, e.l);
      end
    end
    if (timeout) begin
      n_to++;
      to_cyc = cyc;
    end
  end

  int nv;

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    repeat (10) step(1'b0);
    clear_model();
    chk("rst_period", period, 0);
    chk("rst_high_time", high_time, 0);
    chk("rst_period_valid", period_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_no_pulses", n_valid + n_to, 0);
    reset = 1'b0;

    // 2 high / 2 low, lock on the 4th pulse
    pattern(2, 2, 6);
    chk("locked_2_2", locked, 1);
    chk("first_valid_latency", first_valid_cyc - first_push_edge, 1 + SyncLat);

    // Divide-by-7, then 1/1
    pattern(4, 3, 4);
    pattern(1, 1, 6);
    chk("locked_1_1", locked, 1);

    // Relock on 4, then lose the signal
    pattern(2, 2, 5);
    repeat (30) step(1'b0);
    clear_model();
    chk("timeout_once", n_to, 1);
    chk("timeout_delay", to_cyc - last_valid_cyc, TO);
    chk("timeout_locked", locked, 0);
    chk("timeout_period_kept", period, 4);
    chk("timeout_high_kept", high_time, 2);

    nv = n_valid;
    pattern(2, 2, 2);
    repeat (3) step(1'b0);
    chk("post_timeout_valids", n_valid - nv, 1);

    pattern(2, 2, 5);
    chk("locked_before_reset", locked, 1);

    // One-cycle reset mid-period
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
    clear_model();
    chk("midrst_period", period, 0);
    chk("midrst_high_time", high_time, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_period_valid", period_valid, 0);
    chk("midrst_timeout", timeout, 0);

    nv = n_valid;
    pattern(2, 2, 3);
    repeat (4) step(1'b0);
    chk("post_reset_valids", n_valid - nv, 2);
    chk("queue_drained", q.size(), 0);
    chk("timeout_total", n_to, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
